// File: rtl/traffic_phase_scheduler.sv
// Demand-driven two-road phase scheduler with pedestrian walk and night blink.
// Optional TRAFFIC_PED_CLEAR_EN adds a blinking pedestrian-clear phase and walk_blink.
module traffic_phase_scheduler #(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 8,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 3,
  parameter int unsigned CW        = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       modo,
  input  logic       reqA,
  input  logic       reqB,
  input  logic       ped_req,
  output logic       redA,
  output logic       yellowA,
  output logic       greenA,
  output logic       redB,
  output logic       yellowB,
  output logic       greenB,
  output logic       walk,
  output logic       ped_pending,
`ifdef TRAFFIC_PED_CLEAR_EN
  output logic       walk_blink,
`endif
  output logic [3:0] phase
);

`ifdef TRAFFIC_PED_CLEAR_EN
  localparam int unsigned PED_CLEAR_T = 2;
`endif

  typedef enum logic [3:0] {
    A_GREEN   = 4'd0,
    A_YELLOW  = 4'd1,
    ALL_RED   = 4'd2,
    B_GREEN   = 4'd3,
    B_YELLOW  = 4'd4,
    PED_WALK  = 4'd5,
    NIGHT_ON  = 4'd6,
`ifdef TRAFFIC_PED_CLEAR_EN
    PED_CLEAR = 4'd8,
`endif
    NIGHT_OFF = 4'd7
  } state_t;

  state_t          state, next_state, green_next;
  logic            next_road, next_road_nxt;  // 0 = Via A, 1 = Via B
  logic [CW-1:0]   cont;
  logic            ped_clr, ped_pending_nxt;
  logic            red_a_nxt, yellow_a_nxt, green_a_nxt;
  logic            red_b_nxt, yellow_b_nxt, green_b_nxt;
  logic            walk_nxt, blink_nxt;

  // Next-state, pedestrian latch and lamp decode of the upcoming state
  always_comb begin
    next_state    = state;
    next_road_nxt = next_road;
    ped_clr       = 1'b0;
    green_next    = next_road ? B_GREEN : A_GREEN;

    case (state)
      A_GREEN:
        if (modo || ((reqB || ped_pending) &&
                     ((!reqA && cont >= CW'(GREEN_MIN)) || cont >= CW'(GREEN_MAX))))
          next_state = A_YELLOW;
      B_GREEN:
        if (modo || ((reqA || ped_pending) &&
                     ((!reqB && cont >= CW'(GREEN_MIN)) || cont >= CW'(GREEN_MAX))))
          next_state = B_YELLOW;
      A_YELLOW:
        if (cont >= CW'(YELLOW_T)) begin
          next_state    = ALL_RED;
          next_road_nxt = 1'b1;
        end
      B_YELLOW:
        if (cont >= CW'(YELLOW_T)) begin
          next_state    = ALL_RED;
          next_road_nxt = 1'b0;
        end
      ALL_RED:
        if (cont >= CW'(ALLRED_T)) begin
          if (modo)             next_state = NIGHT_ON;
          else if (ped_pending) next_state = PED_WALK;
          else                  next_state = green_next;
        end
      PED_WALK:
        if (cont >= CW'(WALK_T)) begin
`ifdef TRAFFIC_PED_CLEAR_EN
          next_state = PED_CLEAR;
`else
          ped_clr    = 1'b1;
          next_state = modo ? NIGHT_ON : green_next;
`endif
        end
`ifdef TRAFFIC_PED_CLEAR_EN
      PED_CLEAR:
        if (cont >= CW'(PED_CLEAR_T)) begin
          ped_clr    = 1'b1;
          next_state = modo ? NIGHT_ON : green_next;
        end
`endif
      NIGHT_ON:
        if (!modo) begin
          next_state    = ALL_RED;
          next_road_nxt = 1'b0;
        end else begin
          next_state = NIGHT_OFF;
        end
      NIGHT_OFF:
        if (!modo) begin
          next_state    = ALL_RED;
          next_road_nxt = 1'b0;
        end else begin
          next_state = NIGHT_ON;
        end
      default: next_state = ALL_RED;
    endcase

    // Clear beats set; night states hold the latch empty
    if (ped_clr || state == NIGHT_ON || state == NIGHT_OFF)
      ped_pending_nxt = 1'b0;
    else if (ped_req && !modo && state != PED_WALK)
      ped_pending_nxt = 1'b1;
    else
      ped_pending_nxt = ped_pending;

    red_a_nxt    = 1'b0;
    yellow_a_nxt = 1'b0;
    green_a_nxt  = 1'b0;
    red_b_nxt    = 1'b0;
    yellow_b_nxt = 1'b0;
    green_b_nxt  = 1'b0;
    walk_nxt     = 1'b0;
    blink_nxt    = 1'b0;
    case (next_state)
      A_GREEN:   begin green_a_nxt  = 1'b1; red_b_nxt = 1'b1; end
      A_YELLOW:  begin yellow_a_nxt = 1'b1; red_b_nxt = 1'b1; end
      B_GREEN:   begin green_b_nxt  = 1'b1; red_a_nxt = 1'b1; end
      B_YELLOW:  begin yellow_b_nxt = 1'b1; red_a_nxt = 1'b1; end
      PED_WALK:  begin red_a_nxt = 1'b1; red_b_nxt = 1'b1; walk_nxt = 1'b1; end
`ifdef TRAFFIC_PED_CLEAR_EN
      PED_CLEAR: begin red_a_nxt = 1'b1; red_b_nxt = 1'b1; blink_nxt = 1'b1; end
`endif
      NIGHT_ON:  begin yellow_a_nxt = 1'b1; yellow_b_nxt = 1'b1; end
      NIGHT_OFF: ;
      default:   begin red_a_nxt = 1'b1; red_b_nxt = 1'b1; end
    endcase
  end

  // State, phase timer and registered lamp drives
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ALL_RED;
      next_road   <= 1'b0;
      cont        <= CW'(1);
      ped_pending <= 1'b0;
      redA        <= 1'b1;
      yellowA     <= 1'b0;
      greenA      <= 1'b0;
      redB        <= 1'b1;
      yellowB     <= 1'b0;
      greenB      <= 1'b0;
      walk        <= 1'b0;
      phase       <= 4'd2;
`ifdef TRAFFIC_PED_CLEAR_EN
      walk_blink  <= 1'b0;
`endif
    end else begin
      state       <= next_state;
      next_road   <= next_road_nxt;
      ped_pending <= ped_pending_nxt;
      if (next_state != state) cont <= CW'(1);
      else if (cont != '1)     cont <= cont + CW'(1);
      redA        <= red_a_nxt;
      yellowA     <= yellow_a_nxt;
      greenA      <= green_a_nxt;
      redB        <= red_b_nxt;
      yellowB     <= yellow_b_nxt;
      greenB      <= green_b_nxt;
      walk        <= walk_nxt;
      phase       <= 4'(next_state);
`ifdef TRAFFIC_PED_CLEAR_EN
      walk_blink  <= blink_nxt;
`endif
    end
  end

`ifndef TRAFFIC_PED_CLEAR_EN
  logic unused_blink;
  assign unused_blink = blink_nxt;
`endif

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: directed phase sequences with
// hand-computed per-cycle expectations checked by a decoupled monitor.
module tb_traffic_phase_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       modo = 1'b0, reqA = 1'b0, reqB = 1'b0, ped_req = 1'b0;
  logic       redA, yellowA, greenA, redB, yellowB, greenB, walk, ped_pending;
  logic       walk_blink;
  logic [3:0] phase;

  traffic_phase_scheduler dut (
    .clock(clock), .reset(reset), .modo(modo), .reqA(reqA), .reqB(reqB),
    .ped_req(ped_req), .redA(redA), .yellowA(yellowA), .greenA(greenA),
    .redB(redB), .yellowB(yellowB), .greenB(greenB), .walk(walk),
    .ped_pending(ped_pending),
`ifdef TRAFFIC_PED_CLEAR_EN
    .walk_blink(walk_blink),
`endif
    .phase(phase)
  );
`ifndef TRAFFIC_PED_CLEAR_EN
  assign walk_blink = 1'b0;
`endif

  always #5 clock = ~clock;

  logic [12:0] exp_q[$];
  string       tag_q[$];
  string       tag = "reset";
  int          n_checks = 0;
  int          n_fail = 0;
  logic        kick = 1'b0;

  // Lamp pattern per phase code: {rA,yA,gA,rB,yB,gB,walk,blink}
  function automatic logic [7:0] lamps_of(input logic [3:0] ph);
    case (ph)
      4'd0:    return 8'b001_100_0_0;
      4'd1:    return 8'b010_100_0_0;
      4'd2:    return 8'b100_100_0_0;
      4'd3:    return 8'b100_001_0_0;
      4'd4:    return 8'b100_010_0_0;
      4'd5:    return 8'b100_100_1_0;
      4'd6:    return 8'b010_010_0_0;
      4'd7:    return 8'b000_000_0_0;
      4'd8:    return 8'b100_100_0_1;
      default: return 8'hFF;
    endcase
  endfunction

  wire [12:0] act = {phase, redA, yellowA, greenA, redB, yellowB, greenB,
                     walk, walk_blink, ped_pending};

  // Push n expectations, one per rising edge
  task automatic cyc(input logic [3:0] ph, input logic pp, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      exp_q.push_back({ph, lamps_of(ph), pp});
      tag_q.push_back(tag);
    end
  endtask

  // Monitor: compares on each falling edge, or immediately when kicked
  initial begin
    logic [12:0] e;
    string       t;
    forever begin
      @(negedge clock or posedge kick);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_checks++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s @%0t: got phase=%0d lamps=%b pp=%b, expected phase=%0d lamps=%b pp=%b",
                   t, $time, act[12:9], act[8:1], act[0], e[12:9], e[8:1], e[0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tag = "reset";
    cyc(4'd2, 1'b0, 2);
    reset = 1'b1;

    tag = "idle_rest_a";
    cyc(4'd0, 1'b0, 6);

    tag = "max_green_alt";
    reqA = 1'b1; reqB = 1'b1;
    cyc(4'd0, 1'b0, 2);
    cyc(4'd1, 1'b0, 2);
    cyc(4'd2, 1'b0, 1);
    cyc(4'd3, 1'b0, 8);
    cyc(4'd4, 1'b0, 2);
    cyc(4'd2, 1'b0, 1);
    cyc(4'd0, 1'b0, 8);
    cyc(4'd1, 1'b0, 2);
    cyc(4'd2, 1'b0, 1);
    cyc(4'd3, 1'b0, 1);

    tag = "ped_walk";
    reqA = 1'b0; ped_req = 1'b1;
    cyc(4'd3, 1'b1, 1);
    ped_req = 1'b0;
    cyc(4'd3, 1'b1, 6);
    cyc(4'd4, 1'b1, 2);
    cyc(4'd2, 1'b1, 1);
    cyc(4'd5, 1'b1, 3);
`ifdef TRAFFIC_PED_CLEAR_EN
    tag = "ped_clear";
    cyc(4'd8, 1'b1, 2);
`endif
    tag = "ped_done";
    cyc(4'd0, 1'b0, 1);

    tag = "min_green_a";
    cyc(4'd0, 1'b0, 3);
    cyc(4'd1, 1'b0, 2);
    cyc(4'd2, 1'b0, 1);
    cyc(4'd3, 1'b0, 1);

    tag = "min_green_b";
    reqA = 1'b1; reqB = 1'b0;
    cyc(4'd3, 1'b0, 3);
    cyc(4'd4, 1'b0, 2);
    cyc(4'd2, 1'b0, 1);
    cyc(4'd0, 1'b0, 1);

    tag = "night";
    reqA = 1'b0;
    cyc(4'd0, 1'b0, 1);
    modo = 1'b1;
    cyc(4'd1, 1'b0, 2);
    cyc(4'd2, 1'b0, 1);
    cyc(4'd6, 1'b0, 1);
    ped_req = 1'b1;
    cyc(4'd7, 1'b0, 1);
    ped_req = 1'b0;
    cyc(4'd6, 1'b0, 1);
    cyc(4'd7, 1'b0, 1);
    tag = "night_exit";
    modo = 1'b0;
    cyc(4'd2, 1'b0, 1);
    cyc(4'd0, 1'b0, 1);

    tag = "walk_setup";
    ped_req = 1'b1;
    cyc(4'd0, 1'b1, 1);
    ped_req = 1'b0;
    cyc(4'd0, 1'b1, 2);
    cyc(4'd1, 1'b1, 2);
    cyc(4'd2, 1'b1, 1);
    cyc(4'd5, 1'b1, 2);

    tag = "async_reset";
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    exp_q.push_back({4'd2, lamps_of(4'd2), 1'b0});
    tag_q.push_back(tag);
    kick = 1'b1;
    #1 kick = 1'b0;
    cyc(4'd2, 1'b0, 1);
    reset = 1'b1;
    tag = "post_reset";
    cyc(4'd0, 1'b0, 1);

    repeat (3) @(negedge clock);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
Demand-driven phase scheduler for a two-road intersection (Via A / Via B) with a shared pedestrian crossing.
- Replaces fixed-cycle sequencing with per-road vehicle requests, min/max green timing, all-red clearance and a pedestrian walk phase.
- Supports the night blinking-yellow mode.
- Drives the six lamp outputs plus the walk lamp directly; sits between the sensor/button inputs and the lamp drivers.

Parameters:
GREEN_MIN, 4, minimum green cycles before yielding to competing demand
GREEN_MAX, 8, maximum green cycles while competing demand exists
YELLOW_T, 2, yellow duration in cycles
ALLRED_T, 1, all-red clearance duration in cycles
WALK_T, 3, pedestrian walk duration in cycles
CW, 4, phase counter width; must hold max(GREEN_MAX, WALK_T, YELLOW_T, ALLRED_T)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
modo  input  1  0 = day (scheduled), 1 = night (blink)
reqA  input  1  vehicle demand on Via A (level)
reqB  input  1  vehicle demand on Via B (level)
ped_req  input  1  pedestrian button (pulse or level)
redA, yellowA, greenA, redB, yellowB, greenB  output  1 each  lamp drives
walk  output  1  pedestrian walk lamp
ped_pending  output  1  latched pedestrian request
phase  output  4  current state code

Behaviour:
- One clock (clock). Reset is asynchronous, active-low (reset).
- Reset values:
  - state = ALL_RED, next_road = A, cont = 1, ped_pending = 0.
  - Outputs: redA = redB = 1, all other lamps 0, walk = 0, phase = 2.
  - Reset asserted mid-operation aborts any phase immediately.
- State codes:
  - A_GREEN = 0, A_YELLOW = 1, ALL_RED = 2, B_GREEN = 3, B_YELLOW = 4.
  - PED_WALK = 5, NIGHT_ON = 6, NIGHT_OFF = 7, PED_CLEAR = 8 (macro only).
- Outputs are a Moore decode of state and change in the same cycle as state.
  - X_GREEN: greenX = 1, other road red.
  - X_YELLOW: yellowX = 1, other road red.
  - ALL_RED: both red.
  - PED_WALK: both red, walk = 1.
  - NIGHT_ON: yellowA = yellowB = 1.
  - NIGHT_OFF: all lamps 0.
- Timing: cont is set to 1 on entry to every state and increments each cycle, saturating at 2^CW-1. "Held N cycles" means the exit edge occurs when cont == N.
- A_GREEN exit conditions (B_GREEN symmetric, with roles swapped):
  - competing = reqB | ped_pending.
  - Exit to A_YELLOW when competing && !reqA && cont >= GREEN_MIN.
  - Exit to A_YELLOW when competing && cont >= GREEN_MAX.
  - Exit to A_YELLOW when modo == 1, regardless of cont.
  - Otherwise rest in green indefinitely.
- A_YELLOW: held YELLOW_T, then ALL_RED with next_road = B. B_YELLOW is symmetric, setting next_road = A. Day/night mode does not shorten yellow.
- ALL_RED: held ALLRED_T, then:
  - modo == 1 -> NIGHT_ON;
  - else ped_pending -> PED_WALK;
  - else green of next_road.
- PED_WALK: held WALK_T, then green of next_road (or NIGHT_ON if modo == 1). ped_pending clears on PED_WALK exit.
- ped_pending set rules:
  - Set when ped_req == 1 && modo == 0 && state != PED_WALK.
  - Forced to 0 while in NIGHT_ON/NIGHT_OFF.
  - If set and clear coincide, clear wins.
- Night mode:
  - NIGHT_ON and NIGHT_OFF alternate every cycle while modo == 1.
  - When modo == 0 in either night state: go to ALL_RED with next_road = A.
- reqA/reqB are sampled synchronously; simultaneous reqA and reqB are resolved by the max-green rule (alternation).

Optional Feature:
Macro TRAFFIC_PED_CLEAR_EN.
- Defined:
  - Adds output port walk_blink (1 bit).
  - PED_WALK exits to PED_CLEAR instead of green.
  - PED_CLEAR is held 2 cycles: both roads red, walk = 0, walk_blink = 1.
  - Then green of next_road, or NIGHT_ON if modo == 1.
  - ped_pending clears on PED_CLEAR exit.
- Undefined:
  - No port and no state; PED_WALK exits directly as above.

Test Plan:
1. Release reset, reqA = reqB = 0 -> ALL_RED for 1 cycle (both red), then A_GREEN held indefinitely (greenA = 1, redB = 1).
2. reqA = 1, reqB = 1 constant -> A_GREEN 8 cycles, A_YELLOW 2, ALL_RED 1, B_GREEN 8, B_YELLOW 2, ALL_RED 1, then repeat.
3. In A_GREEN, reqA = 0, reqB = 1 -> A_GREEN exits at cont = 4 (4 cycles green), then A_YELLOW 2, ALL_RED 1, B_GREEN.
4. ped_req pulse during B_GREEN, reqB = 1, reqA = 0 -> ped_pending = 1 next cycle; B_GREEN lasts 8 cycles, B_YELLOW 2, ALL_RED 1, PED_WALK 3 (walk = 1, both red), then A_GREEN with ped_pending = 0. With macro defined: 2 cycles of PED_CLEAR (walk_blink = 1) before A_GREEN.
5. modo = 1 at A_GREEN cont = 2 -> A_YELLOW 2, ALL_RED 1, then yellowA/yellowB toggling 1,0,1,0; a ped_req pulse is ignored; modo = 0 -> ALL_RED 1 cycle, then A_GREEN.
6. Reset asserted during PED_WALK cycle 2 -> immediately (asynchronously) redA = redB = 1, walk = 0, ped_pending = 0, phase = 2.
